// File: rtl/cx_crc_multi_unit_if.sv
// CX slave-port bundle for the CRC custom-function unit.
// Request side:  req_valid/req_ready handshake, req_id tag, req_func, req_state,
//                req_data0, req_data1.
// Response side: resp_valid/resp_ready handshake, resp_id, resp_status, resp_data.
// master = requester (CPU side), slave = the CRC unit.
interface cx_crc_multi_unit_if #(
  parameter int unsigned ID_WIDTH = 8
);
  logic                req_valid;
  logic                req_ready;
  logic [ID_WIDTH-1:0] req_id;
  logic [2:0]          req_func;
  logic [3:0]          req_state;
  logic [31:0]         req_data0;
  logic [31:0]         req_data1;

  logic                resp_valid;
  logic                resp_ready;
  logic [ID_WIDTH-1:0] resp_id;
  logic                resp_status;
  logic [31:0]         resp_data;

  modport master (
    output req_valid, req_id, req_func, req_state, req_data0, req_data1, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_status, resp_data
  );

  modport slave (
    input  req_valid, req_id, req_func, req_state, req_data0, req_data1, resp_ready,
    output req_ready, resp_valid, resp_id, resp_status, resp_data
  );
endinterface

// File: rtl/cx_crc_multi_unit.sv
// Multi-context CRC-32 custom-function unit on a CX slave port.
// Keeps NUM_STATES independent reflected CRC accumulators. Functions:
//   INIT (0): acc <= data0, UPDATE (1): fold 1..4 bytes of data0 (count in data1[2:0]),
//   READ (2): return ~acc. One request in flight: IDLE -> (BUSY) -> RESP.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset; aborts any operation, restores INIT_VALUE
//   s_cxu   : CX slave interface (request and response valid/ready handshakes)
module cx_crc_multi_unit #(
  parameter int unsigned NUM_STATES      = 4,
  parameter int unsigned BYTES_PER_CYCLE = 1,
  parameter logic [31:0] POLY            = 32'hEDB88320,
  parameter logic [31:0] INIT_VALUE      = 32'hFFFFFFFF,
  parameter int unsigned ID_WIDTH        = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  cx_crc_multi_unit_if.slave s_cxu
);

  localparam int unsigned SW          = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1;
  localparam logic [2:0]  FUNC_INIT   = 3'd0;
  localparam logic [2:0]  FUNC_UPDATE = 3'd1;
  localparam logic [2:0]  FUNC_READ   = 3'd2;
  localparam logic [2:0]  BPC3        = 3'(BYTES_PER_CYCLE);

  // Reject illegal parameterisations at elaboration.
  if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4) begin : g_bad_bpc
    $error("cx_crc_multi_unit: BYTES_PER_CYCLE must be 1, 2 or 4");
  end
  if (NUM_STATES < 1 || NUM_STATES > 16) begin : g_bad_states
    $error("cx_crc_multi_unit: NUM_STATES must be in 1..16");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} fsm_t;

  fsm_t                fsm_q;
  logic [31:0]         acc_q [NUM_STATES];
  logic [SW-1:0]       idx_q;
  logic [31:0]         crc_q;
  logic [31:0]         data_q;
  logic [2:0]          left_q;
  logic                req_ready_q;
  logic                resp_valid_q;
  logic                resp_status_q;
  logic [ID_WIDTH-1:0] resp_id_q;
  logic [31:0]         resp_data_q;

  logic [SW-1:0]       req_idx_c;
  logic [2:0]          req_n_c;
  logic                req_err_c;
  logic [31:0]         req_acc_c;
  logic [31:0]         crc_next_c;
  logic                unused_c;

  // One reflected CRC byte step, LSB first.
  function automatic logic [31:0] fold_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ ((r[0] ^ b[i]) ? POLY : 32'h0);
    end
    return r;
  endfunction

  // Request decode; index bits above SW are covered by the range check.
  assign req_idx_c = s_cxu.req_state[SW-1:0];
  assign req_n_c   = s_cxu.req_data1[2:0];
  assign req_err_c = (32'(s_cxu.req_state) >= NUM_STATES) ||
                     (s_cxu.req_func > FUNC_READ) ||
                     ((s_cxu.req_func == FUNC_UPDATE) && (req_n_c > 3'd4));
  assign req_acc_c = acc_q[req_idx_c];
  assign unused_c  = ^{s_cxu.req_data1[31:3], s_cxu.req_state};

  // Engine: fold up to BYTES_PER_CYCLE of the remaining bytes this cycle.
  always_comb begin
    crc_next_c = crc_q;
    for (int k = 0; k < int'(BYTES_PER_CYCLE); k++) begin
      if (3'(k) < left_q) begin
        crc_next_c = fold_byte(crc_next_c, data_q[8*k +: 8]);
      end
    end
  end

  // Control FSM, accumulators and registered response.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fsm_q <= ST_IDLE;
      for (int i = 0; i < int'(NUM_STATES); i++) begin
        acc_q[i] <= INIT_VALUE;
      end
      idx_q         <= '0;
      crc_q         <= '0;
      data_q        <= '0;
      left_q        <= '0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_status_q <= 1'b0;
      resp_id_q     <= '0;
      resp_data_q   <= '0;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          if (s_cxu.req_valid && req_ready_q) begin
            resp_id_q     <= s_cxu.req_id;
            idx_q         <= req_idx_c;
            req_ready_q   <= 1'b0;
            resp_status_q <= req_err_c;
            resp_data_q   <= '0;
            resp_valid_q  <= 1'b1;
            fsm_q         <= ST_RESP;
            if (!req_err_c) begin
              case (s_cxu.req_func)
                FUNC_INIT: acc_q[req_idx_c] <= s_cxu.req_data0;
                FUNC_READ: resp_data_q <= ~req_acc_c;
                default: begin
                  // UPDATE: n=0 answers the raw accumulator, otherwise run the engine.
                  if (req_n_c == 3'd0) begin
                    resp_data_q <= req_acc_c;
                  end else begin
                    crc_q        <= req_acc_c;
                    data_q       <= s_cxu.req_data0;
                    left_q       <= req_n_c;
                    resp_valid_q <= 1'b0;
                    fsm_q        <= ST_BUSY;
                  end
                end
              endcase
            end
          end
        end
        ST_BUSY: begin
          if (left_q <= BPC3) begin
            // Last engine cycle: write back before RESP so a following request sees it.
            acc_q[idx_q] <= crc_next_c;
            resp_data_q  <= crc_next_c;
            resp_valid_q <= 1'b1;
            fsm_q        <= ST_RESP;
          end else begin
            crc_q  <= crc_next_c;
            data_q <= data_q >> (8 * BYTES_PER_CYCLE);
            left_q <= left_q - BPC3;
          end
        end
        ST_RESP: begin
          if (s_cxu.resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            fsm_q        <= ST_IDLE;
          end
        end
        default: fsm_q <= ST_IDLE;
      endcase
    end
  end

  assign s_cxu.req_ready   = req_ready_q;
  assign s_cxu.resp_valid  = resp_valid_q;
  assign s_cxu.resp_id     = resp_id_q;
  assign s_cxu.resp_status = resp_status_q;
  assign s_cxu.resp_data   = resp_data_q;

endmodule

// File: tb/tb_cx_crc_multi_unit.sv
// Bench for cx_crc_multi_unit: three instances (BYTES_PER_CYCLE 1, 2, 4) receive the
// same request stream; a scoreboard queue holds expected responses and latencies.
module tb_cx_crc_multi_unit;
  localparam int unsigned NS     = 4;
  localparam logic [31:0] POLY   = 32'hEDB88320;
  localparam logic [2:0]  F_INIT = 3'd0;
  localparam logic [2:0]  F_UPD  = 3'd1;
  localparam logic [2:0]  F_READ = 3'd2;

  typedef struct {
    logic [7:0]  id;
    logic        status;
    logic [31:0] data;
    int          nbytes;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        resp_ready = 1'b1;
  logic [7:0]  req_id = 8'h0;
  logic [2:0]  req_func = 3'd0;
  logic [3:0]  req_state = 4'd0;
  logic [31:0] req_data0 = 32'h0;
  logic [31:0] req_data1 = 32'h0;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic [31:0] acc_m [16];
  logic [7:0]  next_id = 8'h01;
  int          bpc [3] = '{1, 2, 4};

  logic        rv  [3];
  logic        rr  [3];
  logic        rs  [3];
  logic [7:0]  rid [3];
  logic [31:0] rd  [3];

  always #5 clk = ~clk;

  cx_crc_multi_unit_if #(.ID_WIDTH(8)) if1 ();
  cx_crc_multi_unit_if #(.ID_WIDTH(8)) if2 ();
  cx_crc_multi_unit_if #(.ID_WIDTH(8)) if4 ();

  assign if1.req_valid = req_valid;  assign if2.req_valid = req_valid;  assign if4.req_valid = req_valid;
  assign if1.req_id    = req_id;     assign if2.req_id    = req_id;     assign if4.req_id    = req_id;
  assign if1.req_func  = req_func;   assign if2.req_func  = req_func;   assign if4.req_func  = req_func;
  assign if1.req_state = req_state;  assign if2.req_state = req_state;  assign if4.req_state = req_state;
  assign if1.req_data0 = req_data0;  assign if2.req_data0 = req_data0;  assign if4.req_data0 = req_data0;
  assign if1.req_data1 = req_data1;  assign if2.req_data1 = req_data1;  assign if4.req_data1 = req_data1;
  assign if1.resp_ready = resp_ready; assign if2.resp_ready = resp_ready; assign if4.resp_ready = resp_ready;

  assign rv[0] = if1.resp_valid; assign rr[0] = if1.req_ready; assign rs[0] = if1.resp_status;
  assign rid[0] = if1.resp_id;   assign rd[0] = if1.resp_data;
  assign rv[1] = if2.resp_valid; assign rr[1] = if2.req_ready; assign rs[1] = if2.resp_status;
  assign rid[1] = if2.resp_id;   assign rd[1] = if2.resp_data;
  assign rv[2] = if4.resp_valid; assign rr[2] = if4.req_ready; assign rs[2] = if4.resp_status;
  assign rid[2] = if4.resp_id;   assign rd[2] = if4.resp_data;

  cx_crc_multi_unit #(.NUM_STATES(NS), .BYTES_PER_CYCLE(1), .POLY(POLY),
                      .INIT_VALUE(32'hFFFFFFFF), .ID_WIDTH(8))
    u_dut1 (.i_clk(clk), .i_rst_n(rst_n), .s_cxu(if1.slave));
  cx_crc_multi_unit #(.NUM_STATES(NS), .BYTES_PER_CYCLE(2), .POLY(POLY),
                      .INIT_VALUE(32'hFFFFFFFF), .ID_WIDTH(8))
    u_dut2 (.i_clk(clk), .i_rst_n(rst_n), .s_cxu(if2.slave));
  cx_crc_multi_unit #(.NUM_STATES(NS), .BYTES_PER_CYCLE(4), .POLY(POLY),
                      .INIT_VALUE(32'hFFFFFFFF), .ID_WIDTH(8))
    u_dut4 (.i_clk(clk), .i_rst_n(rst_n), .s_cxu(if4.slave));

  // Reference: reflected CRC over n*8 message bits, LSB of byte 0 first.
  function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [31:0] d, input int n);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < n * 8; i++) begin
      if (r[0] != d[i]) r = (r >> 1) ^ POLY;
      else              r = r >> 1;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) acc_m[i] = 32'hFFFFFFFF;
  endtask

  // Drive one request (caller is at a negedge) and push its expected response.
  task automatic issue(input logic [2:0] f, input logic [3:0] s, input logic [31:0] d0,
                       input logic [31:0] d1, input logic use_kat, input logic [31:0] kat);
    exp_t e;
    int   n;
    n = int'(d1[2:0]);
    req_func = f; req_state = s; req_data0 = d0; req_data1 = d1;
    req_id = next_id; next_id = next_id + 8'd1; req_valid = 1'b1;
    e.id = req_id; e.status = 1'b0; e.data = 32'h0; e.nbytes = 0;
    if (f > F_READ || 32'(s) >= NS || (f == F_UPD && n > 4)) e.status = 1'b1;
    else if (f == F_INIT) acc_m[s] = d0;
    else if (f == F_READ) e.data = ~acc_m[s];
    else begin
      if (n > 0) acc_m[s] = crc_model(acc_m[s], d0, n);
      e.data   = acc_m[s];
      e.nbytes = n;
    end
    if (use_kat) e.data = kat;
    exp_q.push_back(e);
  endtask

  // Pop the expected response and match it (with latency) on all three instances.
  task automatic collect(input string name);
    exp_t e;
    bit   seen [3];
    int   k;
    int   lat;
    e = exp_q.pop_front();
    seen = '{0, 0, 0};
    k = 0;
    while (!(seen[0] && seen[1] && seen[2]) && k < 30) begin
      @(negedge clk);
      k++;
      for (int d = 0; d < 3; d++) begin
        if (!seen[d] && rv[d]) begin
          seen[d] = 1'b1;
          lat = (e.nbytes > 0) ? 1 + (e.nbytes + bpc[d] - 1) / bpc[d] : 1;
          checks++;
          if (rid[d] !== e.id) begin
            errors++; $display("FAIL %s bpc%0d id: got %02h expected %02h", name, bpc[d], rid[d], e.id);
          end
          checks++;
          if (rs[d] !== e.status) begin
            errors++; $display("FAIL %s bpc%0d status: got %0b expected %0b", name, bpc[d], rs[d], e.status);
          end
          checks++;
          if (rd[d] !== e.data) begin
            errors++; $display("FAIL %s bpc%0d data: got %08h expected %08h", name, bpc[d], rd[d], e.data);
          end
          checks++;
          if (k != lat) begin
            errors++; $display("FAIL %s bpc%0d latency: got %0d expected %0d", name, bpc[d], k, lat);
          end
        end else if (!seen[d]) begin
          checks++;
          if (rr[d] !== 1'b0) begin
            errors++; $display("FAIL %s bpc%0d req_ready while busy: got %0b expected 0", name, bpc[d], rr[d]);
          end
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      if (!seen[d]) begin
        checks++; errors++;
        $display("FAIL %s bpc%0d response timeout: got none expected id %02h", name, bpc[d], e.id);
      end
    end
  endtask

  task automatic wait_ready(input string name);
    int k;
    @(negedge clk);
    k = 0;
    while (!(rr[0] && rr[1] && rr[2]) && k < 50) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!(rr[0] && rr[1] && rr[2])) begin
      errors++; $display("FAIL %s req_ready timeout: got %0b%0b%0b expected 111", name, rr[0], rr[1], rr[2]);
    end
  endtask

  task automatic send(input logic [2:0] f, input logic [3:0] s, input logic [31:0] d0,
                      input logic [31:0] d1, input logic use_kat, input logic [31:0] kat,
                      input string name);
    wait_ready(name);
    issue(f, s, d0, d1, use_kat, kat);
    @(posedge clk);
    #1 req_valid = 1'b0;
    collect(name);
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({rr[d], rv[d], rs[d], rid[d], rd[d]} !== {1'b1, 1'b0, 1'b0, 8'h0, 32'h0}) begin
        errors++;
        $display("FAIL reset bpc%0d: got ready=%0b valid=%0b status=%0b id=%02h data=%08h expected 1 0 0 00 00000000",
                 bpc[d], rr[d], rv[d], rs[d], rid[d], rd[d]);
      end
    end
  endtask

  task automatic test_update_n0();
    send(F_UPD, 4'd0, 32'h12345678, 32'h0, 1'b1, 32'hFFFFFFFF, "update_n0");
  endtask

  task automatic test_crc_kat();
    send(F_INIT, 4'd0, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h0, "kat_init");
    send(F_UPD,  4'd0, 32'h34333231, 32'd4, 1'b0, 32'h0, "kat_upd1");
    send(F_UPD,  4'd0, 32'h38373635, 32'd4, 1'b0, 32'h0, "kat_upd2");
    send(F_UPD,  4'd0, 32'h00000039, 32'd1, 1'b0, 32'h0, "kat_upd3");
    send(F_READ, 4'd0, 32'h0, 32'h0, 1'b1, 32'hCBF43926, "kat_read");
  endtask

  task automatic test_interleave();
    send(F_INIT, 4'd1, 32'hFFFFFFFF, 32'h0, 1'b0, 32'h0, "ilv_init1");
    send(F_INIT, 4'd2, $urandom, 32'h0, 1'b0, 32'h0, "ilv_init2");
    send(F_UPD,  4'd1, 32'h34333231, 32'd4, 1'b0, 32'h0, "ilv_upd1a");
    send(F_UPD,  4'd2, $urandom, 32'($urandom_range(1, 4)), 1'b0, 32'h0, "ilv_upd2a");
    send(F_UPD,  4'd1, 32'h38373635, 32'd4, 1'b0, 32'h0, "ilv_upd1b");
    send(F_UPD,  4'd2, $urandom, 32'($urandom_range(1, 4)), 1'b0, 32'h0, "ilv_upd2b");
    send(F_UPD,  4'd1, 32'h00000039, 32'd1, 1'b0, 32'h0, "ilv_upd1c");
    send(F_INIT, 4'd2, $urandom, 32'h0, 1'b0, 32'h0, "ilv_init2b");
    send(F_READ, 4'd1, 32'h0, 32'h0, 1'b1, 32'hCBF43926, "ilv_read1");
    send(F_READ, 4'd2, 32'h0, 32'h0, 1'b0, 32'h0, "ilv_read2");
  endtask

  task automatic test_errors();
    send(3'd5,   4'd0, 32'hDEADBEEF, 32'd4, 1'b0, 32'h0, "err_func");
    send(F_INIT, 4'(NS), 32'h11111111, 32'h0, 1'b0, 32'h0, "err_state");
    send(F_UPD,  4'd0, 32'hCAFEF00D, 32'd7, 1'b0, 32'h0, "err_n7");
    send(F_READ, 4'd0, 32'h0, 32'h0, 1'b1, 32'hCBF43926, "err_read");
  endtask

  task automatic test_backpressure();
    exp_t e;
    wait_ready("bp");
    resp_ready = 1'b0;
    issue(F_READ, 4'd1, 32'h0, 32'h0, 1'b1, 32'hCBF43926);
    e = exp_q[0];
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 0; c < 11; c++) begin
      if (c == 5) begin
        // Must be ignored: would clobber state 3 if accepted.
        req_func = F_INIT; req_state = 4'd3; req_data0 = 32'hDEADBEEF; req_id = 8'hEE; req_valid = 1'b1;
      end
      if (c > 0) begin
        @(posedge clk);
        #1 req_valid = 1'b0;
      end
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if ({rv[d], rr[d], rs[d], rid[d], rd[d]} !== {1'b1, 1'b0, e.status, e.id, e.data}) begin
          errors++;
          $display("FAIL bp_hold bpc%0d cyc%0d: got valid=%0b ready=%0b id=%02h data=%08h expected 1 0 %02h %08h",
                   bpc[d], c, rv[d], rr[d], rid[d], rd[d], e.id, e.data);
        end
      end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    void'(exp_q.pop_front());
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({rv[d], rr[d]} !== 2'b01) begin
        errors++; $display("FAIL bp_release bpc%0d: got valid=%0b ready=%0b expected 0 1", bpc[d], rv[d], rr[d]);
      end
    end
    send(F_READ, 4'd3, 32'h0, 32'h0, 1'b1, 32'h0, "bp_read3");
  endtask

  task automatic test_back_to_back();
    int n;
    for (int i = 0; i < 12; i++) begin
      n = $urandom_range(0, 4);
      if (i % 4 == 3) send(F_READ, 4'd3, 32'h0, 32'h0, 1'b0, 32'h0, "b2b_read");
      else send(F_UPD, 4'd3, $urandom, ($urandom & 32'hFFFFFFF8) | 32'(n), 1'b0, 32'h0, "b2b_update");
    end
  endtask

  task automatic test_reset_busy();
    wait_ready("rst_busy");
    req_func = F_UPD; req_state = 4'd0; req_data0 = 32'hAABBCCDD; req_data1 = 32'd4;
    req_id = 8'h5A; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (rv[0] !== 1'b0) begin
        errors++; $display("FAIL rst_busy early resp bpc1: got %0b expected 0", rv[0]);
      end
    end
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({rr[d], rv[d], rs[d], rid[d], rd[d]} !== {1'b1, 1'b0, 1'b0, 8'h0, 32'h0}) begin
        errors++;
        $display("FAIL rst_busy outputs bpc%0d: got ready=%0b valid=%0b id=%02h data=%08h expected 1 0 00 00000000",
                 bpc[d], rr[d], rv[d], rid[d], rd[d]);
      end
    end
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if ({rv[0], rr[0]} !== 2'b01) begin
        errors++; $display("FAIL rst_busy post bpc1 cyc%0d: got valid=%0b ready=%0b expected 0 1", c, rv[0], rr[0]);
      end
    end
    send(F_READ, 4'd0, 32'h0, 32'h0, 1'b1, 32'h00000000, "rst_busy_read");
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_update_n0();
    test_crc_kat();
    test_interleave();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
